// File: rtl/alu_shift_seq.sv
// Multi-step 8-bit shift/rotate unit: performs count+1 single-bit steps of the selected
// operation, one per clock, then pulses done with result, carry and S/Z/P flags.
module alu_shift_seq #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       db,
    input  logic             cy_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic             cy_out,
    output logic             flag_s,
    output logic             flag_z,
    output logic             flag_p
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_RLC = 3'd0;
    localparam logic [2:0] OP_RRC = 3'd1;
    localparam logic [2:0] OP_RL  = 3'd2;
    localparam logic [2:0] OP_RR  = 3'd3;
    localparam logic [2:0] OP_SLA = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    // One extra bit so the maximum count loads 2^CNT_W steps instead of wrapping to 0.
    localparam logic [CNT_W:0] REM_ONE = {{CNT_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [7:0]       w_q, w_d;
    logic             c_q, c_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W:0]   rem_q, rem_d;

    logic             sin;
    logic             go_left;
    logic [7:0]       step_w;
    logic             step_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            w_q     <= 8'h00;
            c_q     <= 1'b0;
            op_q    <= 3'd0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            c_q     <= c_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (rem_q == REM_ONE) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sin = 1'b0;
        case (op_q)
            OP_RLC:         sin = w_q[7];
            OP_RRC:         sin = w_q[0];
            OP_RL, OP_RR:   sin = c_q;
            OP_SLA, OP_SRL: sin = 1'b0;
            OP_SRA:         sin = w_q[7];
            OP_SLL:         sin = 1'b1;
            default:        sin = 1'b0;
        endcase
    end

    // Even opcodes shift left, odd opcodes shift right.
    assign go_left = ~op_q[0];
    assign step_w  = go_left ? {w_q[6:0], sin} : {sin, w_q[7:1]};
    assign step_c  = go_left ? w_q[7] : w_q[0];

    always_comb begin
        w_d   = w_q;
        c_d   = c_q;
        op_d  = op_q;
        rem_d = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d   = db;
                    c_d   = cy_in;
                    op_d  = op;
                    rem_d = {1'b0, count} + REM_ONE;
                end
            end
            S_SHIFT: begin
                w_d   = step_w;
                c_d   = step_c;
                rem_d = rem_q - REM_ONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign result = w_q;
    assign cy_out = c_q;
    assign flag_s = w_q[7];
    assign flag_z = (w_q == 8'h00);
    assign flag_p = ~^w_q;

endmodule
